// File: rtl/mcu_ctrl_alu_core.sv
// Sequencer, instruction decode and ALU for the 8-bit / 12-bit-instruction MCU.
// Define MCU_ALU_SHIFT_EN to enable the rotate/shift ALU modes A-E (otherwise they pass b through).
module mcu_ctrl_alu_core #(
  parameter logic [7:0] LOAD_LAST = 8'd25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ir,
  input  logic [3:0]  sr,
  input  logic [7:0]  pc,
  input  logic [7:0]  acc,
  input  logic [7:0]  dr,
  output logic [1:0]  stage,
  output logic [7:0]  load_addr,
  output logic        load_done,
  output logic        clr,
  output logic        pc_e,
  output logic        acc_e,
  output logic        sr_e,
  output logic        ir_e,
  output logic        dr_e,
  output logic        pmem_e,
  output logic        pmem_le,
  output logic        dmem_e,
  output logic        dmem_we,
  output logic        alu_e,
  output logic        mux1_sel,
  output logic        mux2_sel,
  output logic [3:0]  alu_mode,
  output logic [7:0]  pc_plus1,
  output logic [7:0]  pc_next,
  output logic [7:0]  alu_out,
  output logic [3:0]  flags_out
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DECODE  = 2'b10,
    ST_EXECUTE = 2'b11
  } stage_t;

  stage_t     stage_q, stage_d;
  logic [7:0] load_addr_q, load_addr_d;
  logic       load_done_q, load_done_d;

  always_comb begin
    stage_d     = stage_q;
    load_addr_d = load_addr_q;
    load_done_d = load_done_q;
    case (stage_q)
      ST_LOAD: begin
        if (!load_done_q) begin
          if (load_addr_q == LOAD_LAST) begin
            load_addr_d = 8'd0;
            load_done_d = 1'b1;
          end else begin
            load_addr_d = load_addr_q + 8'd1;
          end
        end else begin
          stage_d = ST_FETCH;
        end
      end
      ST_FETCH:   stage_d = ST_DECODE;
      ST_DECODE:  stage_d = ST_EXECUTE;
      default:    stage_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= ST_LOAD;
      load_addr_q <= 8'd0;
      load_done_q <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      load_addr_q <= load_addr_d;
      load_done_q <= load_done_d;
    end
  end

  assign stage     = stage_q;
  assign load_addr = load_addr_q;
  assign load_done = load_done_q;

  // Decode priority in EXECUTE: I-type, Jcc, M-type, GOTO, NOP.
  always_comb begin
    clr      = 1'b0;
    pc_e     = 1'b0;
    acc_e    = 1'b0;
    sr_e     = 1'b0;
    ir_e     = 1'b0;
    dr_e     = 1'b0;
    pmem_e   = 1'b0;
    pmem_le  = 1'b0;
    dmem_e   = 1'b0;
    dmem_we  = 1'b0;
    alu_e    = 1'b0;
    mux1_sel = 1'b0;
    mux2_sel = 1'b0;
    alu_mode = 4'h0;
    case (stage_q)
      ST_LOAD: begin
        if (!load_done_q) begin
          pmem_e  = 1'b1;
          pmem_le = 1'b1;
        end else begin
          clr = 1'b1;
        end
      end
      ST_FETCH: begin
        ir_e   = 1'b1;
        pmem_e = 1'b1;
      end
      ST_DECODE: begin
        if (ir[11:9] == 3'b001) begin
          dr_e   = 1'b1;
          dmem_e = 1'b1;
        end
      end
      default: begin
        pc_e = 1'b1;
        if (ir[11]) begin
          alu_mode = {1'b0, ir[10:8]};
          alu_e    = 1'b1;
          acc_e    = 1'b1;
          sr_e     = 1'b1;
        end else if (ir[10]) begin
          mux1_sel = sr[ir[9:8]];
        end else if (ir[9]) begin
          alu_mode = ir[7:4];
          mux2_sel = 1'b1;
          alu_e    = 1'b1;
          sr_e     = 1'b1;
          if (ir[8]) begin
            acc_e = 1'b1;
          end else begin
            dmem_e  = 1'b1;
            dmem_we = 1'b1;
          end
        end else if (ir[8]) begin
          mux1_sel = 1'b1;
        end
      end
    endcase
  end

  assign pc_plus1 = pc + 8'd1;
  assign pc_next  = mux1_sel ? ir[7:0] : pc_plus1;

  logic [7:0] b_op;
  logic [8:0] sum;
  logic [7:0] res;
  logic       c_flag, o_flag;

  assign b_op = mux2_sel ? dr : ir[7:0];

  // Non-arithmetic modes leave C and O as they were in sr.
  always_comb begin
    sum    = 9'd0;
    res    = 8'h00;
    c_flag = sr[2];
    o_flag = sr[0];
    case (alu_mode)
      4'h0: begin
        sum    = {1'b0, acc} + {1'b0, b_op};
        res    = sum[7:0];
        c_flag = sum[8];
        o_flag = (acc[7] == b_op[7]) && (res[7] != acc[7]);
      end
      4'h1: begin
        sum    = {1'b0, acc} - {1'b0, b_op};
        res    = sum[7:0];
        c_flag = sum[8];
        o_flag = (acc[7] != b_op[7]) && (res[7] != acc[7]);
      end
      4'h2: res = acc;
      4'h3: res = b_op;
      4'h4: res = acc & b_op;
      4'h5: res = acc | b_op;
      4'h6: res = acc ^ b_op;
      4'h7: begin
        sum    = {1'b0, b_op} - {1'b0, acc};
        res    = sum[7:0];
        c_flag = sum[8];
        o_flag = (b_op[7] != acc[7]) && (res[7] != b_op[7]);
      end
      4'h8: begin
        sum    = {1'b0, b_op} + 9'd1;
        res    = sum[7:0];
        c_flag = sum[8];
        o_flag = (b_op == 8'h7F);
      end
      4'h9: begin
        sum    = {1'b0, b_op} - 9'd1;
        res    = sum[7:0];
        c_flag = sum[8];
        o_flag = (b_op == 8'h80);
      end
`ifdef MCU_ALU_SHIFT_EN
      4'hA: res = (b_op << acc[2:0]) | (b_op >> (4'd8 - {1'b0, acc[2:0]}));
      4'hB: res = (b_op >> acc[2:0]) | (b_op << (4'd8 - {1'b0, acc[2:0]}));
      4'hC: res = b_op << acc[2:0];
      4'hD: res = b_op >> acc[2:0];
      4'hE: res = $signed(b_op) >>> acc[2:0];
`else
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: res = b_op;
`endif
      default: begin
        res    = 8'h00 - b_op;
        c_flag = (b_op != 8'h00);
        o_flag = (b_op == 8'h80);
      end
    endcase
  end

  assign alu_out   = alu_e ? res : 8'h00;
  assign flags_out = alu_e ? {(res == 8'h00), c_flag, res[7], o_flag} : sr;

endmodule

// File: tb/tb_mcu_ctrl_alu_core.sv
// Directed-vector bench for mcu_ctrl_alu_core: load sequence, EXECUTE decode/ALU table, reset mid-run.
module tb_mcu_ctrl_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ir;
  logic [3:0]  sr;
  logic [7:0]  pc, acc, dr;
  logic [1:0]  stage;
  logic [7:0]  load_addr;
  logic        load_done, clr;
  logic        pc_e, acc_e, sr_e, ir_e, dr_e;
  logic        pmem_e, pmem_le, dmem_e, dmem_we, alu_e;
  logic        mux1_sel, mux2_sel;
  logic [3:0]  alu_mode;
  logic [7:0]  pc_plus1, pc_next, alu_out;
  logic [3:0]  flags_out;

  mcu_ctrl_alu_core dut (
    .clk(clk), .rst(rst), .ir(ir), .sr(sr), .pc(pc), .acc(acc), .dr(dr),
    .stage(stage), .load_addr(load_addr), .load_done(load_done), .clr(clr),
    .pc_e(pc_e), .acc_e(acc_e), .sr_e(sr_e), .ir_e(ir_e), .dr_e(dr_e),
    .pmem_e(pmem_e), .pmem_le(pmem_le), .dmem_e(dmem_e), .dmem_we(dmem_we), .alu_e(alu_e),
    .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .alu_mode(alu_mode),
    .pc_plus1(pc_plus1), .pc_next(pc_next), .alu_out(alu_out), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // Enable bus order: pc,acc,sr,ir,dr,pmem,pmem_le,dmem,dmem_we,alu,mux1,mux2.
  logic [11:0] enBus;
  assign enBus = {pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, dmem_e, dmem_we, alu_e, mux1_sel, mux2_sel};

  typedef struct {
    logic [11:0] ir;
    logic [3:0]  sr;
    logic [7:0]  pc;
    logic [7:0]  acc;
    logic [7:0]  dr;
    logic [7:0]  expOut;
    logic [3:0]  expFlags;
    logic [7:0]  expPcNext;
    logic [3:0]  expMode;
    logic [11:0] expEn;
  } vec_t;

  vec_t vecs [14];
  int nVectors = 0;
  int nMiscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] i, input logic [3:0] s, input logic [7:0] p,
                               input logic [7:0] a, input logic [7:0] d);
    ir = i; sr = s; pc = p; acc = a; dr = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           ir      sr     pc     acc    dr     out    flags    pcnext mode  enables
    vecs[0]  = '{12'h805, 4'h0, 8'h10, 8'hFE, 8'h00, 8'h03, 4'b0100, 8'h11, 4'h0, 12'hE04};
    vecs[1]  = '{12'h203, 4'h0, 8'h20, 8'h7F, 8'h01, 8'h80, 4'b0011, 8'h21, 4'h0, 12'hA1D};
    vecs[2]  = '{12'h73C, 4'h8, 8'h30, 8'h00, 8'h00, 8'h00, 4'b1000, 8'h3C, 4'h0, 12'h802};
    vecs[3]  = '{12'h73C, 4'h0, 8'h30, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h31, 4'h0, 12'h800};
    vecs[4]  = '{12'h110, 4'h5, 8'h40, 8'h00, 8'h00, 8'h00, 4'b0101, 8'h10, 4'h0, 12'h802};
    vecs[5]  = '{12'h000, 4'h0, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 4'h0, 12'h800};
    vecs[6]  = '{12'h905, 4'h0, 8'h50, 8'h03, 8'h00, 8'hFE, 4'b0110, 8'h51, 4'h1, 12'hE04};
    vecs[7]  = '{12'hC0F, 4'h5, 8'h60, 8'hF0, 8'h00, 8'h00, 4'b1101, 8'h61, 4'h4, 12'hE04};
    vecs[8]  = '{12'hF01, 4'h0, 8'h70, 8'h80, 8'h00, 8'h81, 4'b0111, 8'h71, 4'h7, 12'hE04};
    vecs[9]  = '{12'h3F0, 4'h0, 8'h80, 8'h00, 8'h80, 8'h80, 4'b0111, 8'h81, 4'hF, 12'hE05};
    vecs[10] = '{12'h3A0, 4'h5, 8'h90, 8'h05, 8'h81, 8'h81, 4'b0111, 8'h91, 4'hA, 12'hE05};
    vecs[11] = '{12'h380, 4'h0, 8'hA0, 8'h00, 8'h7F, 8'h80, 4'b0011, 8'hA1, 4'h8, 12'hE05};
    vecs[12] = '{12'hA00, 4'h0, 8'hB0, 8'h00, 8'h00, 8'h00, 4'b1000, 8'hB1, 4'h2, 12'hE04};
    vecs[13] = '{12'h390, 4'h0, 8'hC0, 8'h00, 8'h00, 8'hFF, 4'b0110, 8'hC1, 4'h9, 12'hE05};

    rst = 1'b1;
    applyStimulus(12'h000, 4'h0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_stage", {30'd0, stage}, 32'd0);
    checkOutput("reset_load_addr", {24'd0, load_addr}, 32'd0);
    checkOutput("reset_load_done", {31'd0, load_done}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i <= 25; i++) begin
      checkOutput($sformatf("load_addr_%0d", i), {24'd0, load_addr}, i);
      checkOutput($sformatf("load_en_%0d", i), {19'd0, load_done, enBus}, 32'h060);
      tick();
    end

    checkOutput("load_done_set", {31'd0, load_done}, 32'd1);
    checkOutput("load_addr_wrap", {24'd0, load_addr}, 32'd0);
    checkOutput("load_done_clr", {19'd0, clr, enBus}, 32'h1000);
    checkOutput("load_done_stage", {30'd0, stage}, 32'd0);
    tick();

    checkOutput("fetch_stage", {30'd0, stage}, 32'd1);
    checkOutput("fetch_en", {19'd0, clr, enBus}, 32'h140);
    applyStimulus(12'h203, 4'h0, 8'h00, 8'h7F, 8'h01);
    tick();
    checkOutput("decode_stage", {30'd0, stage}, 32'd2);
    checkOutput("decode_mtype_en", {20'd0, enBus}, 32'h090);
    tick();

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].ir, vecs[v].sr, vecs[v].pc, vecs[v].acc, vecs[v].dr);
      #1;
      checkOutput($sformatf("v%0d_stage", v), {29'd0, load_done, stage}, 32'h7);
      checkOutput($sformatf("v%0d_alu_out", v), {24'd0, alu_out}, {24'd0, vecs[v].expOut});
      checkOutput($sformatf("v%0d_flags", v), {28'd0, flags_out}, {28'd0, vecs[v].expFlags});
      checkOutput($sformatf("v%0d_pc_next", v), {24'd0, pc_next}, {24'd0, vecs[v].expPcNext});
      checkOutput($sformatf("v%0d_alu_mode", v), {28'd0, alu_mode}, {28'd0, vecs[v].expMode});
      checkOutput($sformatf("v%0d_enables", v), {19'd0, clr, enBus}, {20'd0, vecs[v].expEn});
      repeat (3) @(posedge clk);
      #1;
    end

    applyStimulus(12'h805, 4'h0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("decode_itype_stage", {30'd0, stage}, 32'd2);
    checkOutput("decode_itype_en", {20'd0, enBus}, 32'h000);
    tick();

    applyStimulus(12'h203, 4'h0, 8'h00, 8'h7F, 8'h01);
    #1;
    checkOutput("pre_reset_dmem_we", {31'd0, dmem_we}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_stage", {30'd0, stage}, 32'd0);
    checkOutput("midrst_load_addr", {24'd0, load_addr}, 32'd0);
    checkOutput("midrst_load_done", {31'd0, load_done}, 32'd0);
    checkOutput("midrst_dmem_we", {31'd0, dmem_we}, 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
